// File: rtl/clock_monitor.sv
// rtl/clock_monitor.sv - period / lock / timeout health monitor for a divided clock (optional CLOCK_MONITOR_SYNC_EN)
`timescale 1ns/1ps

module clock_monitor #(
    parameter int EXP_PERIOD = 100,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clock1M,
    input  logic             reset,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o,
    output logic             locked_o,
    output logic             err_o,
    output logic             timeout_o,
    output logic [7:0]       err_count_o
);

    localparam int LC_W = $clog2(LOCK_COUNT + 1);

    // Tolerance window is evaluated one bit wider than the counter so cnt+1 never wraps.
    localparam logic [CNT_W:0]   TOL_LO  = (EXP_PERIOD > TOL) ? (CNT_W+1)'(EXP_PERIOD - TOL) : '0;
    localparam logic [CNT_W:0]   TOL_HI  = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(2 * EXP_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LC_W-1:0]  LC_MAX  = LC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [LC_W-1:0]  lock_cnt;
    logic             s;
    logic             p;
    logic             rise;
    logic [CNT_W:0]   meas;
    logic             in_tol;
    logic [LC_W-1:0]  lc_inc;

`ifdef CLOCK_MONITOR_SYNC_EN
    logic sync_q;

    // Two-flop synchronizer (sync_q then s) followed by the edge-history flop p.
    always_ff @(posedge clock1M) begin
        if (reset) begin
            sync_q <= 1'b0;
            s      <= 1'b0;
            p      <= 1'b0;
        end else begin
            sync_q <= clk_in;
            s      <= sync_q;
            p      <= s;
        end
    end
`else
    // clk_in is already synchronous to clock1M: sample it directly, then keep one cycle of history.
    always_ff @(posedge clock1M) begin
        if (reset) begin
            s <= 1'b0;
            p <= 1'b0;
        end else begin
            s <= clk_in;
            p <= s;
        end
    end
`endif

    assign rise   = s & ~p;
    assign meas   = {1'b0, cnt} + (CNT_W+1)'(1);
    assign in_tol = (meas >= TOL_LO) && (meas <= TOL_HI);
    assign lc_inc = (lock_cnt == LC_MAX) ? LC_MAX : lock_cnt + LC_W'(1);

    // Period counter, lock state machine and all registered outputs.
    always_ff @(posedge clock1M) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            lock_cnt       <= '0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
            locked_o       <= 1'b0;
            err_o          <= 1'b0;
            timeout_o      <= 1'b0;
            err_count_o    <= '0;
        end else begin
            period_valid_o <= 1'b0;
            err_o          <= 1'b0;
            timeout_o      <= 1'b0;

            if (state == IDLE || rise) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    // First edge only starts a measurement; it carries no period.
                    if (rise) begin
                        state    <= ACQUIRE;
                        lock_cnt <= '0;
                    end
                end
                ACQUIRE, LOCKED: begin
                    if (rise) begin
                        period_o       <= meas[CNT_W-1:0];
                        period_valid_o <= 1'b1;
                        if (in_tol) begin
                            lock_cnt <= lc_inc;
                            if (lc_inc == LC_MAX) begin
                                state    <= LOCKED;
                                locked_o <= 1'b1;
                            end
                        end else begin
                            err_o    <= 1'b1;
                            lock_cnt <= '0;
                            state    <= ACQUIRE;
                            locked_o <= 1'b0;
                            if (err_count_o != 8'hFF) begin
                                err_count_o <= err_count_o + 8'd1;
                            end
                        end
                    end else if (cnt == TMO_CNT) begin
                        // Edge overdue by a full 2x period: give up and wait for a fresh first edge.
                        timeout_o <= 1'b1;
                        lock_cnt  <= '0;
                        state     <= IDLE;
                        locked_o  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lock_cnt <= '0;
                    locked_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
